// File: rtl/hv_timing_gen_if.sv
// Video timing bundle between the timing generator and the game core /
// video back end. clk and reset_n stay outside as plain ports.
interface hv_timing_gen_if #(
  parameter int HW = 9,
  parameter int VW = 9,
  parameter int CW = 12
);
  logic               ce_pix;
  logic signed [3:0]  h_adj;
  logic signed [3:0]  v_adj;
  logic [CW-1:0]      rgb_in;
  logic [HW-1:0]      hpos;
  logic [VW-1:0]      vpos;
  logic               line_start;
  logic               frame_start;
  logic [CW-1:0]      rgb_out;
  logic               hblank;
  logic               vblank;
  logic               hs_n;
  logic               vs_n;

  // Timing generator side.
  modport master (
    input  ce_pix, h_adj, v_adj, rgb_in,
    output hpos, vpos, line_start, frame_start,
    output rgb_out, hblank, vblank, hs_n, vs_n
  );

  // Core / consumer side.
  modport slave (
    output ce_pix, h_adj, v_adj, rgb_in,
    input  hpos, vpos, line_start, frame_start,
    input  rgb_out, hblank, vblank, hs_n, vs_n
  );
endinterface

// File: rtl/hv_timing_gen.sv
// Parametrised H/V video timing generator: binary pixel/line counters,
// per-frame latched sync trim, and a one-pixel-delayed blanked RGB stage.
module hv_timing_gen #(
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 23,
  parameter int H_SYNC   = 31,
  parameter int H_BP     = 42,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 29,
  parameter int CW       = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  hv_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = ((HW > VW) ? HW : VW) + 2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic signed [SW-1:0] FP_MIN   = SW'(1);
  localparam logic signed [SW-1:0] H_FP_S   = SW'(H_FP);
  localparam logic signed [SW-1:0] H_FP_MAX = SW'(H_FP + H_BP - 1);
  localparam logic signed [SW-1:0] V_FP_S   = SW'(V_FP);
  localparam logic signed [SW-1:0] V_FP_MAX = SW'(V_FP + V_BP - 1);

  logic [HW-1:0]       hpos;
  logic [VW-1:0]       vpos;
  logic                h_wrap;
  logic                v_wrap;
  logic signed [3:0]   h_sh;
  logic signed [3:0]   v_sh;

  logic signed [SW-1:0] hfp_raw, hfp;
  logic signed [SW-1:0] vfp_raw, vfp;
  logic [SW-1:0]        hpos_x, vpos_x;
  logic [SW-1:0]        hs_start, hs_end;
  logic [SW-1:0]        vs_start, vs_end;
  logic                 hb, vb, hsy, vsy;

  logic [CW-1:0]        rgb_q;
  logic                 hblank_q, vblank_q, hs_n_q, vs_n_q;
  logic                 line_start_q, frame_start_q;

  assign h_wrap = (hpos == H_LAST);
  assign v_wrap = (vpos == V_LAST);

  // Pixel and line counters, advancing only on the pixel enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (vid.ce_pix) begin
      hpos <= h_wrap ? '0 : hpos + HW'(1);
      if (h_wrap)
        vpos <= v_wrap ? '0 : vpos + VW'(1);
    end
  end

  // Sync trim shadows, captured only on the 0/0 wrap so a frame never changes shape mid-way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_sh <= '0;
      v_sh <= '0;
    end else if (vid.ce_pix && h_wrap && v_wrap) begin
      h_sh <= vid.h_adj;
      v_sh <= vid.v_adj;
    end
  end

  // Effective front porch: nominal plus trim, clamped so both porches stay at least one unit.
  always_comb begin
    hfp_raw = H_FP_S + SW'({{(SW-4){h_sh[3]}}, h_sh});
    vfp_raw = V_FP_S + SW'({{(SW-4){v_sh[3]}}, v_sh});

    if (hfp_raw < FP_MIN)        hfp = FP_MIN;
    else if (hfp_raw > H_FP_MAX) hfp = H_FP_MAX;
    else                         hfp = hfp_raw;

    if (vfp_raw < FP_MIN)        vfp = FP_MIN;
    else if (vfp_raw > V_FP_MAX) vfp = V_FP_MAX;
    else                         vfp = vfp_raw;
  end

  // Blank and sync decode from the live counters.
  always_comb begin
    hpos_x   = SW'(hpos);
    vpos_x   = SW'(vpos);
    hs_start = SW'(H_ACTIVE) + $unsigned(hfp);
    hs_end   = hs_start + SW'(H_SYNC);
    vs_start = SW'(V_ACTIVE) + $unsigned(vfp);
    vs_end   = vs_start + SW'(V_SYNC);
    hb       = (hpos_x >= SW'(H_ACTIVE));
    vb       = (vpos_x >= SW'(V_ACTIVE));
    hsy      = (hpos_x >= hs_start) && (hpos_x < hs_end);
    vsy      = (vpos_x >= vs_start) && (vpos_x < vs_end);
  end

  // Output stage: blanked pixel and flags, one pixel behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q    <= '0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      hs_n_q   <= 1'b1;
      vs_n_q   <= 1'b1;
    end else if (vid.ce_pix) begin
      rgb_q    <= (hb || vb) ? '0 : vid.rgb_in;
      hblank_q <= hb;
      vblank_q <= vb;
      hs_n_q   <= ~hsy;
      vs_n_q   <= ~vsy;
    end
  end

  // Line/frame start strobes: one clk wide regardless of how long ce_pix stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= vid.ce_pix && h_wrap;
      frame_start_q <= vid.ce_pix && h_wrap && v_wrap;
    end
  end

  assign vid.hpos        = hpos;
  assign vid.vpos        = vpos;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.rgb_out     = rgb_q;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.hs_n        = hs_n_q;
  assign vid.vs_n        = vs_n_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Bench for hv_timing_gen: a reduced-geometry instance checked cycle by cycle
// against a behavioural model through an expected-output queue, plus a
// default-geometry instance checked for its headline line timing.
module tb_hv_timing_gen;

  localparam int S_HW  = 5;
  localparam int S_VW  = 4;
  localparam int S_HA  = 16;
  localparam int S_HFP = 3;
  localparam int S_HSY = 4;
  localparam int S_HBP = 5;
  localparam int S_VA  = 8;
  localparam int S_VFP = 2;
  localparam int S_VSY = 2;
  localparam int S_VBP = 3;
  localparam int S_HT  = S_HA + S_HFP + S_HSY + S_HBP;  // 28
  localparam int S_VT  = S_VA + S_VFP + S_VSY + S_VBP;  // 15
  localparam int S_FRAME = S_HT * S_VT;                  // 420

  typedef struct packed {
    logic [11:0] rgb;
    logic        hb;
    logic        vb;
    logic        hs_n;
    logic        vs_n;
  } exp_t;

  localparam exp_t RST_EXP = exp_t'{12'h000, 1'b1, 1'b1, 1'b1, 1'b1};

  logic clk   = 1'b0;
  logic rst_s = 1'b0;
  logic rst_d = 1'b0;

  always #5 clk = ~clk;

  hv_timing_gen_if #(.HW(S_HW), .VW(S_VW), .CW(12)) vs ();
  hv_timing_gen_if #(.HW(9),    .VW(9),    .CW(12)) vd ();

  hv_timing_gen #(
    .HW(S_HW), .VW(S_VW),
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
    .CW(12)
  ) u_small (
    .clk(clk),
    .reset_n(rst_s),
    .vid(vs.master)
  );

  hv_timing_gen u_def (
    .clk(clk),
    .reset_n(rst_d),
    .vid(vd.master)
  );

  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state for the reduced instance.
  int   mh, mv, sh_h, sh_v;
  exp_t cur;
  exp_t q[$];
  int   cyc;
  int   last_ls;
  bit   per_chk;
  int   fff_cnt;
  int   ce_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; sh_h = 0; sh_v = 0;
    cur = RST_EXP;
    q.delete();
    last_ls = -1;
  endtask

  task automatic chk_reset_small();
    chk("rst_hpos",   32'(vs.hpos), 0);
    chk("rst_vpos",   32'(vs.vpos), 0);
    chk("rst_rgb",    32'(vs.rgb_out), 0);
    chk("rst_hblank", 32'(vs.hblank), 1);
    chk("rst_vblank", 32'(vs.vblank), 1);
    chk("rst_hs_n",   32'(vs.hs_n), 1);
    chk("rst_vs_n",   32'(vs.vs_n), 1);
    chk("rst_ls",     32'(vs.line_start), 0);
    chk("rst_fs",     32'(vs.frame_start), 0);
  endtask

  // One clk of the reduced instance: predict, push, clock, pop, compare.
  task automatic small_cycle(input logic ce, input logic [11:0] rgb);
    exp_t e;
    bit   ls_e, fs_e, wh, wv;
    int   hfp, vfp;
    vs.ce_pix = ce;
    vs.rgb_in = rgb;
    ls_e = 1'b0;
    fs_e = 1'b0;
    if (ce) begin
      hfp    = clampi(S_HFP + sh_h, 1, S_HFP + S_HBP - 1);
      vfp    = clampi(S_VFP + sh_v, 1, S_VFP + S_VBP - 1);
      e.hb   = (mh >= S_HA);
      e.vb   = (mv >= S_VA);
      e.hs_n = !((mh >= S_HA + hfp) && (mh < S_HA + hfp + S_HSY));
      e.vs_n = !((mv >= S_VA + vfp) && (mv < S_VA + vfp + S_VSY));
      e.rgb  = (e.hb || e.vb) ? 12'h000 : rgb;
      q.push_back(e);
      wh   = (mh == S_HT - 1);
      wv   = (mv == S_VT - 1);
      ls_e = wh;
      fs_e = wh && wv;
      if (wh && wv) begin
        sh_h = int'(vs.h_adj);
        sh_v = int'(vs.v_adj);
      end
      mh = wh ? 0 : mh + 1;
      if (wh) mv = wv ? 0 : mv + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0) cur = q.pop_front();
    chk("hpos",        32'(vs.hpos), 32'(mh));
    chk("vpos",        32'(vs.vpos), 32'(mv));
    chk("rgb_out",     32'(vs.rgb_out), 32'(cur.rgb));
    chk("hblank",      32'(vs.hblank), 32'(cur.hb));
    chk("vblank",      32'(vs.vblank), 32'(cur.vb));
    chk("hs_n",        32'(vs.hs_n), 32'(cur.hs_n));
    chk("vs_n",        32'(vs.vs_n), 32'(cur.vs_n));
    chk("line_start",  32'(vs.line_start), 32'(ls_e));
    chk("frame_start", 32'(vs.frame_start), 32'(fs_e));
    if (ce) begin
      ce_cnt++;
      if (vs.rgb_out == 12'hFFF) fff_cnt++;
    end
    if (vs.line_start) begin
      if (per_chk && last_ls >= 0) chk("ls_period", 32'(cyc - last_ls), 32'(4 * S_HT));
      last_ls = cyc;
    end
  endtask

  initial begin
    int w, c, hbc;
    bit found;

    vs.ce_pix = 1'b0; vs.h_adj = '0; vs.v_adj = '0; vs.rgb_in = '0;
    vd.ce_pix = 1'b1; vd.h_adj = '0; vd.v_adj = '0; vd.rgb_in = 12'hABC;
    cyc = 0; fff_cnt = 0; ce_cnt = 0; per_chk = 1'b0;
    model_reset();

    // Reset held while clk and ce_pix toggle.
    for (int i = 0; i < 4; i++) begin
      vs.ce_pix = i[0];
      @(posedge clk);
      #1;
      chk_reset_small();
    end
    chk("def_rst_hpos", 32'(vd.hpos), 0);
    chk("def_rst_hs_n", 32'(vd.hs_n), 1);
    chk("def_rst_hblank", 32'(vd.hblank), 1);

    // Phase A: ce every 4th clk, constant white input, two frames.
    rst_s = 1'b1;
    per_chk = 1'b1;
    for (int i = 0; i < 4 * 2 * S_FRAME; i++) begin
      small_cycle(((i % 4) == 3), 12'hFFF);
      if (((i % 4) == 3) && ce_cnt == 5) begin
        chk("hpos_after_5ce", 32'(vs.hpos), 5);
        chk("vpos_after_5ce", 32'(vs.vpos), 0);
      end
    end
    chk("fff_pixels", 32'(fff_cnt), 32'(2 * S_HA * S_VA));
    per_chk = 1'b0;

    // Phase B: random enables/pixels, mid-frame trims including both clamp ends.
    for (int i = 0; i < 200; i++)
      small_cycle(1'($urandom_range(0, 1)), 12'($urandom));
    vs.h_adj = 4'sd3; vs.v_adj = -4'sd8;
    for (int i = 0; i < 1500; i++)
      small_cycle(1'($urandom_range(0, 1)), 12'($urandom));
    vs.h_adj = 4'sd7; vs.v_adj = 4'sd7;
    for (int i = 0; i < 1200; i++)
      small_cycle(1'($urandom_range(0, 1)), 12'($urandom));
    vs.h_adj = -4'sd8; vs.v_adj = 4'sd0;
    for (int i = 0; i < 1200; i++)
      small_cycle(1'($urandom_range(0, 1)), 12'($urandom));

    // Phase C: ce held high, async reset while both syncs are asserted.
    vs.h_adj = 4'sd2; vs.v_adj = 4'sd0;
    found = 1'b0;
    for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
      small_cycle(1'b1, 12'($urandom));
      if (cur.hs_n == 1'b0 && cur.vs_n == 1'b0) found = 1'b1;
    end
    chk("found_sync_region", 32'(found), 1);
    rst_s = 1'b0;
    #2;
    chk_reset_small();
    @(posedge clk);
    #1;
    chk_reset_small();
    rst_s = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * S_FRAME + 20; i++)
      small_cycle(1'b1, 12'($urandom));
    vs.ce_pix = 1'b0;

    // Default geometry, ce held high.
    rst_d = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("def_hpos_5", 32'(vd.hpos), 5);
    chk("def_vpos_5", 32'(vd.vpos), 0);
    w = 0;
    while (vd.hs_n !== 1'b0 && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    chk("def_hs_fall_seen", 32'(w < 1000), 1);
    chk("def_hpos_at_hs_fall", 32'(vd.hpos), 312);
    w = 0;
    while (vd.hs_n === 1'b0 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("def_hs_width", 32'(w), 31);
    c = 0;
    while (vd.line_start !== 1'b1 && c < 1000) begin
      @(posedge clk); #1; c++;
    end
    chk("def_ls_seen", 32'(c < 1000), 1);
    chk("def_ls_hpos", 32'(vd.hpos), 0);
    c = 0; hbc = 0;
    do begin
      @(posedge clk); #1; c++;
      if (vd.hblank) hbc++;
    end while (vd.line_start !== 1'b1 && c < 1000);
    chk("def_line_period", 32'(c), 384);
    chk("def_hblank_width", 32'(hbc), 96);
    chk("def_vpos_line2", 32'(vd.vpos), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
